// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the M-extension execute unit: funct3 op codes and FSM states.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_S_IDLE = 2'd0,
    MD_S_MUL  = 2'd1,
    MD_S_DIV  = 2'd2,
    MD_S_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// One restoring-division step on magnitudes: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and shift in the quotient bit.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The partial remainder is always below the divisor, so the difference fits in XLEN bits.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    fits    = shifted >= {1'b0, divisor_i};
    diff    = shifted[XLEN-1:0] - divisor_i;
    rem_o   = fits ? diff : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage (shift-add multiplier, restoring divider).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational one.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_i,
  input  logic [2:0]            md_op_i,
  input  logic [XLEN-1:0]       A_i,
  input  logic [XLEN-1:0]       B_i,
  input  logic [REG_ADDR_W-1:0] Rd_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] Rd_o
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e             state_q, state_d;
  md_op_e                op_q, op_d, opIn;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       accHi_q, accHi_d, accLo_q, accLo_d, opB_q, opB_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  negRes_q, negRes_d;

  logic                  accept, isDivIn, aSignedIn, bSignedIn, sA, sB, divByZero, overflow;
  logic [XLEN-1:0]       absA, absB;
  logic [XLEN:0]         mulSum;
  logic [XLEN-1:0]       mulHi, mulLo, divRem, divQuo, mulResult, divResult;
  logic [2*XLEN-1:0]     product, productFix;

  assign opIn      = md_op_e'(md_op_i);
  assign accept    = (state_q == MD_S_IDLE) && valid_i && !flush;
  assign isDivIn   = md_op_i[2];
  assign aSignedIn = (opIn == MD_MULH) || (opIn == MD_MULHSU) || (opIn == MD_DIV) || (opIn == MD_REM);
  assign bSignedIn = (opIn == MD_MULH) || (opIn == MD_DIV) || (opIn == MD_REM);
  assign sA        = aSignedIn && A_i[XLEN-1];
  assign sB        = bSignedIn && B_i[XLEN-1];
  assign absA      = sA ? -A_i : A_i;
  assign absB      = sB ? -B_i : B_i;
  assign divByZero = (B_i == '0);
  assign overflow  = ((opIn == MD_DIV) || (opIn == MD_REM)) &&
                     (A_i == {1'b1, {(XLEN-1){1'b0}}}) && (B_i == '1);

  // Shift-add step: {accHi, accLo} holds partial product above the remaining multiplier bits.
  assign mulSum     = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : {(XLEN+1){1'b0}});
  assign mulHi      = mulSum[XLEN:1];
  assign mulLo      = {mulSum[0], accLo_q[XLEN-1:1]};
  assign product    = {mulHi, mulLo};
  assign productFix = negRes_q ? -product : product;
  assign mulResult  = (op_q == MD_MUL) ? productFix[XLEN-1:0] : productFix[2*XLEN-1:XLEN];

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .rem_i     (accHi_q),
    .quo_i     (accLo_q),
    .divisor_i (opB_q),
    .rem_o     (divRem),
    .quo_o     (divQuo)
  );

  always_comb begin
    divResult = '0;
    if ((op_q == MD_DIV) || (op_q == MD_DIVU)) divResult = negRes_q ? -divQuo : divQuo;
    else                                       divResult = negRes_q ? -divRem : divRem;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fastProd, fastFix;
  logic [XLEN-1:0]   fastResult;

  assign fastProd   = {{XLEN{1'b0}}, absA} * {{XLEN{1'b0}}, absB};
  assign fastFix    = (sA ^ sB) ? -fastProd : fastProd;
  assign fastResult = (opIn == MD_MUL) ? fastFix[XLEN-1:0] : fastFix[2*XLEN-1:XLEN];
`endif

  // Next-state logic; flush overrides everything and leaves the last result visible.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    opB_d    = opB_q;
    result_d = result_q;
    rd_d     = rd_q;
    negRes_d = negRes_q;
    case (state_q)
      MD_S_IDLE: begin
        if (accept) begin
          op_d     = opIn;
          rd_d     = Rd_i;
          cnt_d    = '0;
          negRes_d = ((opIn == MD_REM) || (opIn == MD_REMU)) ? sA : (sA ^ sB);
          accHi_d  = '0;
          accLo_d  = absA;
          opB_d    = absB;
          if (isDivIn && divByZero) begin
            result_d = ((opIn == MD_DIV) || (opIn == MD_DIVU)) ? '1 : A_i;
            state_d  = MD_S_DONE;
          end else if (overflow) begin
            result_d = (opIn == MD_DIV) ? A_i : '0;
            state_d  = MD_S_DONE;
          end else if (isDivIn) begin
            state_d = MD_S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = fastResult;
            state_d  = MD_S_DONE;
`else
            state_d = MD_S_MUL;
`endif
          end
        end
      end
      MD_S_MUL: begin
        accHi_d = mulHi;
        accLo_d = mulLo;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          result_d = mulResult;
          state_d  = MD_S_DONE;
        end
      end
      MD_S_DIV: begin
        accHi_d = divRem;
        accLo_d = divQuo;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          result_d = divResult;
          state_d  = MD_S_DONE;
        end
      end
      MD_S_DONE: state_d = MD_S_IDLE;
      default:   state_d = MD_S_IDLE;
    endcase
    if (flush) begin
      state_d  = MD_S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_S_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      opB_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      negRes_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      accHi_q  <= accHi_d;
      accLo_q  <= accLo_d;
      opB_q    <= opB_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      negRes_q <= negRes_d;
    end
  end

  assign stall_o  = !rst && !flush &&
                    (accept || (state_q == MD_S_MUL) || (state_q == MD_S_DIV));
  assign done_o   = (state_q == MD_S_DONE);
  assign result_o = result_q;
  assign Rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32): directed table, random ops against
// an arithmetic reference model, and hand-written flush/reset sequences.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam int RW   = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst, flush, valid;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic [RW-1:0]   rd;
  logic            stall_o, done_o;
  logic [XLEN-1:0] result_o;
  logic [RW-1:0]   Rd_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  ex_muldiv_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .valid_i  (valid),
    .md_op_i  (op),
    .A_i      (a),
    .B_i      (b),
    .Rd_i     (rd),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .Rd_o     (Rd_o)
  );

  always #5 clk = ~clk;

  // Reference model straight from the RISC-V M-extension definitions using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] opIn, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    p  = '0;
    case (opIn)
      3'd0: p = ux * uy;
      3'd1: p = 64'(sx * sy) >> 32;
      3'd2: p = 64'(sx * longint'(uy)) >> 32;
      3'd3: p = (ux * uy) >> 32;
      3'd4: begin
        if (y == 0) p = '1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, x};
        else p = 64'(sx / sy);
      end
      3'd5: p = (y == 0) ? '1 : ux / uy;
      3'd6: begin
        if (y == 0) p = {32'd0, x};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = '0;
        else p = 64'(sx % sy);
      end
      default: p = (y == 0) ? {32'd0, x} : ux % uy;
    endcase
    return p[31:0];
  endfunction

  function automatic int refLatency(input logic [2:0] opIn, input logic [31:0] x, input logic [31:0] y);
    if (!opIn[2]) return MUL_LAT;
    if (y == 0) return 1;
    if ((opIn == 3'd4 || opIn == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one instruction starting at the current (negedge) cycle T and holds valid like a stalled pipeline.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] rdIn, input logic [31:0] expRes, input int expLat,
                               input string name);
    int cycles;
    bit stallOk;
    bit seen;
    valid = 1'b1;
    op    = opIn;
    a     = x;
    b     = y;
    rd    = rdIn;
    #1;
    checkOutput({name, " stall@T"}, {31'd0, stall_o}, 32'd1);
    cycles  = 0;
    stallOk = 1'b1;
    seen    = 1'b0;
    while (!seen && cycles < 200) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (done_o) seen = 1'b1;
      else if (!stall_o) stallOk = 1'b0;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({name, " stall-held"}, {31'd0, stallOk}, 32'd1);
    if (seen) begin
      checkOutput({name, " result"}, result_o, expRes);
      checkOutput({name, " rd"}, {27'd0, Rd_o}, {27'd0, rdIn});
      checkOutput({name, " stall@done"}, {31'd0, stall_o}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    #1;
    checkOutput({name, " no-reaccept"}, {30'd0, stall_o, done_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        DIV_LAT});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         DIV_LAT});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    rst   = 1'b1;
    flush = 1'b0;
    valid = 1'b1;
    op    = 3'd0;
    a     = 32'd3;
    b     = 32'd4;
    rd    = 5'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset outputs", {stall_o, done_o, Rd_o, result_o[24:0]}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].res, vecs[i].lat,
                    $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(rop, ra, rb, 5'($urandom), refModel(rop, ra, rb), refLatency(rop, ra, rb),
                    $sformatf("rnd%0d op%0d a=%08h b=%08h", i, rop, ra, rb));
    end

    // Flush racing a new instruction in IDLE must win.
    applyStimulus(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT, "pre-flush");
    valid = 1'b1;
    flush = 1'b1;
    op    = 3'd0;
    a     = 32'd9;
    b     = 32'd9;
    #1;
    checkOutput("flush+valid stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("flush+valid no accept", {30'd0, stall_o, done_o}, 32'd0);

    // Flush at T+10 of a DIV, then a MUL accepted at T+11.
    @(negedge clk);
    valid = 1'b1;
    op    = 3'd4;
    a     = 32'd1000;
    b     = 32'd3;
    rd    = 5'd4;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush stall drop", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush no done", {31'd0, done_o}, 32'd0);
    checkOutput("flush result kept", result_o, 32'd14);
    applyStimulus(3'd0, 32'd12, 32'd13, 5'd5, 32'd156, MUL_LAT, "post-flush mul");

    // Reset pulse at T+5 of a MUL.
    @(negedge clk);
    valid = 1'b1;
    op    = 3'd0;
    a     = 32'd6;
    b     = 32'd7;
    rd    = 5'd9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset result", result_o, 32'd0);
    checkOutput("midreset flags", {26'd0, Rd_o, done_o}, 32'd0);
    checkOutput("midreset stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    checkOutput("after reset idle", {30'd0, stall_o, done_o}, 32'd0);
    @(negedge clk);
    applyStimulus(3'd0, 32'd6, 32'd7, 5'd9, 32'd42, MUL_LAT, "post-reset mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
